lib_sample_checker: RTL and testbench

- Receive-side monitor for the counter/divider outputs of the library sample block.
- Samples an incoming counter stream and divided-clock level on CLK, acquires lock after LOCK_CNT consecutive correct samples, then flags, counts and optionally captures any deviation from the expected sequence.
- Sits on the consumer side of CNTR_OUT*/CLK_OUT_DIV in characterisation and test benches.

---
 rtl/lib_sample_pkg.sv | 12 +
 rtl/lib_sample_seq_match.sv | 18 +
 rtl/lib_sample_checker.sv | 144 ++++++++++++++
 tb/tb_lib_sample_checker.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/lib_sample_pkg.sv
// Shared state encoding and default counter width for the library sample checker/generator pair.
package lib_sample_pkg;

  localparam int WIDTH = 3;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ACQUIRE = 2'd1,
    ST_TRACK   = 2'd2
  } state_t;

endpackage

// File: rtl/lib_sample_seq_match.sv
// Combinational sequence comparator: the new sample matches when the counter advanced by one
// (modulo 2^WIDTH) and the divided-clock level toggled.
module lib_sample_seq_match #(
  parameter int WIDTH = lib_sample_pkg::WIDTH
) (
  input  logic [WIDTH-1:0] prev_cntr,
  input  logic             prev_div,
  input  logic [WIDTH-1:0] cntr,
  input  logic             div,
  output logic             match
);

  logic [WIDTH-1:0] exp_cntr;

  assign exp_cntr = prev_cntr + WIDTH'(1);
  assign match    = (cntr == exp_cntr) && (div != prev_div);

endmodule

// File: rtl/lib_sample_checker.sv
// Receive-side lock/error monitor for a counter stream plus divided-clock level.
// Optional capture of the first locked mismatch: define LIB_SAMPLE_CHK_CAPTURE_EN.
module lib_sample_checker #(
  parameter int WIDTH    = lib_sample_pkg::WIDTH,
  parameter int LOCK_CNT = 4,
  parameter int ERR_W    = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             EN,
  input  logic [WIDTH-1:0] CNTR_IN,
  input  logic             DIV_IN,
  input  logic             CLR_ERR,
  output logic             LOCKED,
  output logic             ERR_PULSE,
  output logic [ERR_W-1:0] ERR_CNT,
  output logic [1:0]       STATE
`ifdef LIB_SAMPLE_CHK_CAPTURE_EN
  ,
  output logic [WIDTH-1:0] ERR_DATA,
  output logic [WIDTH-1:0] ERR_EXP
`endif
);

  import lib_sample_pkg::*;

  localparam logic [7:0] LOCK_V = 8'(LOCK_CNT);

  function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] v);
    return (&v) ? v : v + ERR_W'(1);
  endfunction

  state_t           state, state_nx;
  logic [7:0]       good_cnt, good_nx;
  logic [WIDTH-1:0] prev_cntr;
  logic             prev_div;
  logic             match;
  logic             locked_nx;
  logic             pulse_nx;
  logic             err_hit;

  lib_sample_seq_match #(.WIDTH(WIDTH)) u_match (
    .prev_cntr (prev_cntr),
    .prev_div  (prev_div),
    .cntr      (CNTR_IN),
    .div       (DIV_IN),
    .match     (match)
  );

  always_comb begin
    state_nx  = state;
    good_nx   = good_cnt;
    locked_nx = LOCKED;
    pulse_nx  = 1'b0;
    err_hit   = 1'b0;
    if (!EN) begin
      state_nx  = ST_IDLE;
      locked_nx = 1'b0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          // First sample only seeds prev_*; it is never judged.
          good_nx   = 8'd0;
          locked_nx = 1'b0;
          state_nx  = ST_ACQUIRE;
        end
        ST_ACQUIRE: begin
          if (match) begin
            good_nx = good_cnt + 8'd1;
            if (good_cnt + 8'd1 == LOCK_V) begin
              state_nx  = ST_TRACK;
              locked_nx = 1'b1;
            end
          end else begin
            good_nx = 8'd0;
          end
        end
        ST_TRACK: begin
          if (!match) begin
            pulse_nx  = 1'b1;
            err_hit   = 1'b1;
            locked_nx = 1'b0;
            good_nx   = 8'd0;
            state_nx  = ST_ACQUIRE;
          end
        end
        default: begin
          state_nx  = ST_IDLE;
          locked_nx = 1'b0;
          good_nx   = 8'd0;
        end
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= ST_IDLE;
      good_cnt  <= 8'd0;
      prev_cntr <= '0;
      prev_div  <= 1'b0;
      LOCKED    <= 1'b0;
      ERR_PULSE <= 1'b0;
      ERR_CNT   <= '0;
    end else begin
      state     <= state_nx;
      good_cnt  <= good_nx;
      LOCKED    <= locked_nx;
      ERR_PULSE <= pulse_nx;
      if (EN) begin
        prev_cntr <= CNTR_IN;
        prev_div  <= DIV_IN;
      end
      // Clear takes precedence over a coincident increment.
      if (CLR_ERR) begin
        ERR_CNT <= '0;
      end else if (err_hit) begin
        ERR_CNT <= sat_inc(ERR_CNT);
      end
    end
  end

  assign STATE = state;

`ifdef LIB_SAMPLE_CHK_CAPTURE_EN
  logic             cap_done;
  logic [WIDTH-1:0] exp_cntr;

  assign exp_cntr = prev_cntr + WIDTH'(1);

  always_ff @(posedge CLK) begin
    if (RST || CLR_ERR) begin
      cap_done <= 1'b0;
      ERR_DATA <= '0;
      ERR_EXP  <= '0;
    end else if (err_hit && !cap_done) begin
      cap_done <= 1'b1;
      ERR_DATA <= CNTR_IN;
      ERR_EXP  <= exp_cntr;
    end
  end
`endif

endmodule

// File: tb/tb_lib_sample_checker.sv
// Directed bench for lib_sample_checker (ERR_W=2 so saturation is reachable quickly).
module tb_lib_sample_checker;

  logic       CLK = 1'b0;
  logic       RST;
  logic       EN;
  logic [2:0] CNTR_IN;
  logic       DIV_IN;
  logic       CLR_ERR;
  logic       LOCKED;
  logic       ERR_PULSE;
  logic [1:0] ERR_CNT;
  logic [1:0] STATE;
`ifdef LIB_SAMPLE_CHK_CAPTURE_EN
  logic [2:0] ERR_DATA;
  logic [2:0] ERR_EXP;
`endif

  int checks = 0;
  int errors = 0;
  logic [2:0] cv;
  logic       dv;

  lib_sample_checker #(.WIDTH(3), .LOCK_CNT(4), .ERR_W(2)) dut (
    .CLK       (CLK),
    .RST       (RST),
    .EN        (EN),
    .CNTR_IN   (CNTR_IN),
    .DIV_IN    (DIV_IN),
    .CLR_ERR   (CLR_ERR),
    .LOCKED    (LOCKED),
    .ERR_PULSE (ERR_PULSE),
    .ERR_CNT   (ERR_CNT),
    .STATE     (STATE)
`ifdef LIB_SAMPLE_CHK_CAPTURE_EN
    ,
    .ERR_DATA  (ERR_DATA),
    .ERR_EXP   (ERR_EXP)
`endif
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [1:0] st, input logic lk,
                         input logic pl, input logic [1:0] ec);
    chk({tag, ".state"},   32'(STATE),     32'(st));
    chk({tag, ".locked"},  32'(LOCKED),    32'(lk));
    chk({tag, ".pulse"},   32'(ERR_PULSE), 32'(pl));
    chk({tag, ".err_cnt"}, 32'(ERR_CNT),   32'(ec));
  endtask

  task automatic chk_cap(input string tag, input logic [2:0] data, input logic [2:0] exp);
`ifdef LIB_SAMPLE_CHK_CAPTURE_EN
    chk({tag, ".err_data"}, 32'(ERR_DATA), 32'(data));
    chk({tag, ".err_exp"},  32'(ERR_EXP),  32'(exp));
`else
    if (tag.len() < 0) $display("%0d %0d", data, exp);
`endif
  endtask

  task automatic sample(input logic [2:0] c, input logic d);
    EN      = 1'b1;
    CNTR_IN = c;
    DIV_IN  = d;
    @(posedge CLK);
    #1;
  endtask

  task automatic good();
    cv = cv + 3'd1;
    dv = ~dv;
    sample(cv, dv);
  endtask

  task automatic skip();
    cv = cv + 3'd2;
    dv = ~dv;
    sample(cv, dv);
  endtask

  initial begin
    RST = 1'b1; EN = 1'b0; CNTR_IN = '0; DIV_IN = 1'b0; CLR_ERR = 1'b0;
    cv = 3'd7; dv = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    chk_all("reset", 2'd0, 1'b0, 1'b0, 2'd0);
    chk_cap("reset", 3'd0, 3'd0);
    RST = 1'b0;

    // Lock on 0,1,2,3,4
    good(); chk_all("lock_s0", 2'd1, 1'b0, 1'b0, 2'd0);
    good(); good(); good();
    chk_all("lock_s3", 2'd1, 1'b0, 1'b0, 2'd0);
    good(); chk_all("lock_s4", 2'd2, 1'b1, 1'b0, 2'd0);

    // Wrap 5,6,7,0,1
    repeat (5) begin
      good(); chk_all("wrap", 2'd2, 1'b1, 1'b0, 2'd0);
    end

    // 2,3 then 5: error while tracking, expected 4
    good(); good();
    skip(); chk_all("track_err", 2'd1, 1'b0, 1'b1, 2'd1);
    chk_cap("track_err", 3'd5, 3'd4);
    good(); chk_all("relock_s6", 2'd1, 1'b0, 1'b0, 2'd1);
    good(); good(); chk_all("relock_s0", 2'd1, 1'b0, 1'b0, 2'd1);
    good(); chk_all("relock_s1", 2'd2, 1'b1, 1'b0, 2'd1);

    // Counter correct but DIV level repeated
    good();
    cv = cv + 3'd1;
    sample(cv, dv);
    chk_all("div_fault", 2'd1, 1'b0, 1'b1, 2'd2);
    chk_cap("div_fault", 3'd5, 3'd4);
    repeat (4) good();
    chk_all("relock2", 2'd2, 1'b1, 1'b0, 2'd2);

    // Enable dropped mid-track
    EN = 1'b0;
    @(posedge CLK);
    #1;
    chk_all("en_off", 2'd0, 1'b0, 1'b0, 2'd2);
    good(); chk_all("restart", 2'd1, 1'b0, 1'b0, 2'd2);
    repeat (4) good();
    chk_all("relock3", 2'd2, 1'b1, 1'b0, 2'd2);

    // Clear while locked: FSM unaffected
    CLR_ERR = 1'b1;
    good();
    CLR_ERR = 1'b0;
    chk_all("clr", 2'd2, 1'b1, 1'b0, 2'd0);
    chk_cap("clr", 3'd0, 3'd0);

    // Five locked errors saturate at 3; first one (exp 6, got 7) stays captured
    for (int k = 1; k <= 5; k++) begin
      skip();
      chk_all("sat_err", 2'd1, 1'b0, 1'b1, (k > 3) ? 2'd3 : 2'(k));
      chk_cap("sat_err", 3'd7, 3'd6);
      repeat (4) good();
      chk_all("sat_relock", 2'd2, 1'b1, 1'b0, (k > 3) ? 2'd3 : 2'(k));
    end

    // Clear coinciding with a sixth error: clear wins
    CLR_ERR = 1'b1;
    skip();
    CLR_ERR = 1'b0;
    chk_all("clr_vs_err", 2'd1, 1'b0, 1'b1, 2'd0);
    chk_cap("clr_vs_err", 3'd0, 3'd0);
    repeat (4) good();
    chk_all("relock4", 2'd2, 1'b1, 1'b0, 2'd0);

    // One more error (exp 2, got 3), relock, then reset mid-track
    skip();
    chk_all("pre_rst_err", 2'd1, 1'b0, 1'b1, 2'd1);
    chk_cap("pre_rst_err", 3'd3, 3'd2);
    repeat (4) good();
    chk_all("pre_rst", 2'd2, 1'b1, 1'b0, 2'd1);
    RST = 1'b1;
    good();
    RST = 1'b0;
    chk_all("rst_track", 2'd0, 1'b0, 1'b0, 2'd0);
    chk_cap("rst_track", 3'd0, 3'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
